// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle RV32I datapath: walks each instruction through
// fetch/decode/execute/writeback and drives the datapath muxes and write enables.
module multicycle_control_fsm #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q, state_d;
    logic   ready;
    logic   pc_write_d, mem_write_d, ir_write_d, reg_write_d, illegal_d;

    assign ready = USE_MEM_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Unreachable encodings fall through to the defaults: all outputs 0, next state FETCH.
    always_comb begin
        state_d     = state_q;
        pc_write_d  = 1'b0;
        adr_src     = 1'b0;
        mem_write_d = 1'b0;
        ir_write_d  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_d = ready;
                pc_write_d = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_d = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_d = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_d = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write_d = zero;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked by rst_n so they drop the moment reset asserts, not at the next edge.
    assign pc_write   = pc_write_d  & rst_n;
    assign mem_write  = mem_write_d & rst_n;
    assign ir_write   = ir_write_d  & rst_n;
    assign reg_write  = reg_write_d & rst_n;
    assign illegal_op = illegal_d   & rst_n;

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction phase lists with
// memory stalls, checked cycle by cycle against the per-phase output table.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    int vectors = 0;
    int errors  = 0;

    localparam int P_FETCH = 0, P_DEC = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_JAL = 9, P_BEQ = 10;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

    string pname [11] = '{"fetch", "decode", "memadr", "memread", "memwb", "memwrite",
                          "execr", "execi", "aluwb", "jal", "beq"};

    multicycle_control_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JAL) || (o == BEQ);
    endfunction

    // Expected output bundle {pcw, adr, mw, irw, rs, a, b, aop, imm, rw, ill} for one cycle.
    function automatic logic [15:0] expect_out(input int ph, input logic [6:0] o,
                                               input logic z, input logic rdy);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, aop, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
        imm = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        case (ph)
            P_FETCH:  begin pcw = rdy; irw = rdy; rs = 2'b10; b = 2'b10; end
            P_DEC:    begin a = 2'b01; b = 2'b01; ill = !is_legal(o); end
            P_MEMADR: begin a = 2'b10; b = 2'b01; end
            P_MEMRD:  adr = 1;
            P_MEMWB:  begin rs = 2'b01; rw = 1; end
            P_MEMWR:  begin adr = 1; mw = 1; end
            P_EXECR:  begin a = 2'b10; aop = 2'b10; end
            P_EXECI:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            P_ALUWB:  rw = 1;
            P_JAL:    begin a = 2'b01; b = 2'b10; pcw = 1; end
            P_BEQ:    begin a = 2'b10; aop = 2'b01; pcw = z; end
            default:  ;
        endcase
        return {pcw, adr, mw, irw, rs, a, b, aop, imm, rw, ill};
    endfunction

    function automatic logic [15:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                alu_op, imm_src, reg_write, illegal_op};
    endfunction

    // Entered on a negedge; each cycle drives inputs, checks after 1ns, then waits for the next negedge.
    // fstall/mstall: number of mem_ready=0 cycles in the fetch / data-memory phase.
    // abort_rst: pulse reset during the second memwrite cycle and leave the instruction there.
    task automatic run_instr(input logic [6:0] o, input int fstall, input int mstall,
                             input bit abort_rst);
        int ph[$];
        int stalls;
        logic [15:0] exp_v, obs_v;
        ph = {P_FETCH, P_DEC};
        case (o)
            LW:  ph = {ph, P_MEMADR, P_MEMRD, P_MEMWB};
            SW:  ph = {ph, P_MEMADR, P_MEMWR};
            RT:  ph = {ph, P_EXECR, P_ALUWB};
            IT:  ph = {ph, P_EXECI, P_ALUWB};
            JAL: ph = {ph, P_JAL, P_ALUWB};
            BEQ: ph = {ph, P_BEQ};
            default: ;
        endcase
        foreach (ph[k]) begin
            stalls = (ph[k] == P_FETCH) ? fstall :
                     (ph[k] == P_MEMRD || ph[k] == P_MEMWR) ? mstall : 0;
            for (int c = 0; c <= stalls; c++) begin
                op   = o;
                zero = 1'($urandom);
                if (ph[k] == P_FETCH || ph[k] == P_MEMRD || ph[k] == P_MEMWR)
                    mem_ready = (c == stalls);
                else
                    mem_ready = 1'($urandom);
                #1;
                exp_v = expect_out(ph[k], o, zero, mem_ready);
                obs_v = observed();
                vectors++;
                assert (obs_v === exp_v) else begin
                    errors++;
                    $error("FAIL %s op=%b cyc=%0d: observed %h expected %h",
                           pname[ph[k]], o, c, obs_v, exp_v);
                end
                if (abort_rst && ph[k] == P_MEMWR && c == 1) begin
                    #2 rst_n = 1'b0;
                    #1;
                    vectors++;
                    assert ({pc_write, mem_write, ir_write, reg_write, illegal_op} === 5'b0)
                    else begin
                        errors++;
                        $error("FAIL async_reset: observed %b expected 00000",
                               {pc_write, mem_write, ir_write, reg_write, illegal_op});
                    end
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [6:0] legal[6];
        logic [6:0] o;
        legal = '{LW, SW, RT, IT, JAL, BEQ};
        rst_n = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
        #1;
        vectors++;
        assert ({pc_write, mem_write, ir_write, reg_write, illegal_op} === 5'b0) else begin
            errors++;
            $error("FAIL reset_enables: observed %b expected 00000",
                   {pc_write, mem_write, ir_write, reg_write, illegal_op});
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: each instruction class, stalls, illegal op, reset during memwrite.
        run_instr(LW, 0, 0, 1'b0);
        run_instr(BEQ, 0, 0, 1'b0);
        run_instr(JAL, 0, 0, 1'b0);
        run_instr(RT, 0, 0, 1'b0);
        run_instr(IT, 0, 0, 1'b0);
        run_instr(SW, 0, 3, 1'b0);
        run_instr(LW, 2, 2, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0);
        run_instr(BEQ, 3, 0, 1'b0);
        run_instr(SW, 0, 3, 1'b1);
        run_instr(RT, 0, 0, 1'b0);

        // Randomised instruction stream with occasional unsupported opcodes.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                o = 7'($urandom);
                while (is_legal(o)) o = 7'($urandom);
            end else begin
                o = legal[$urandom_range(0, 5)];
            end
            run_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end
        run_instr(BEQ, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
